// File: rtl/rv32_branch_pkg.sv
// Shared definitions for the branch-resolve block.
//   - RV32I conditional-branch funct3 codes
//   - FSM state encoding for the redirect/flush sequencer
package rv32_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } brState_e;

endpackage

// File: rtl/branch_resolve_decide.sv
// branch_decide: pure combinational branch outcome.
//   valid, jump, funct3 : instruction in EX
//   brEq, brLt          : comparator flags
//   taken               : branch/jump redirects the PC
//   illegalF3           : funct3 010/011 on a conditional branch
//   brUn                : comparator unsigned select
module branch_decide
  import rv32_branch_pkg::*;
(
  input  logic       valid,
  input  logic       jump,
  input  logic [2:0] funct3,
  input  logic       brEq,
  input  logic       brLt,
  output logic       taken,
  output logic       illegalF3,
  output logic       brUn
);

  // funct3[1] separates BLTU/BGEU from the signed compares.
  assign brUn      = valid & ~jump & funct3[1];
  assign illegalF3 = ~jump & (funct3[2:1] == 2'b01);

  always_comb begin
    taken = 1'b0;
    if (jump) begin
      taken = 1'b1;
    end else begin
      unique case (funct3)
        F3_BEQ:           taken = brEq;
        F3_BNE:           taken = ~brEq;
        F3_BLT, F3_BLTU:  taken = brLt;
        F3_BGE, F3_BGEU:  taken = ~brLt;
        default:          taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves EX-stage branches/jumps, drives the PC redirect
// and the front-end flush, and counts branch events for debug.
//   clk, rst_n            : clock, async active-low reset
//   br_valid/funct3/jump  : branch/jump in EX; br_target its target
//   BrEQ, BrLT / BrUN     : comparator flags in / unsigned select out
//   br_ready              : a branch can be accepted this cycle
//   pc_sel, pc_target     : registered PC-mux redirect
//   flush                 : registered IF/ID squash, FLUSH_CYC cycles long
//   illegal               : one-cycle pulse after accepting funct3 010/011
//   cnt_clr, cnt_branch, cnt_taken : debug event counters
module branch_resolve
  import rv32_branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  input  logic [2:0]        br_funct3,
  input  logic              br_jump,
  input  logic [DATA_W-1:0] br_target,
  input  logic              BrEQ,
  input  logic              BrLT,
  output logic              BrUN,
  output logic              br_ready,
  output logic              pc_sel,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush,
  output logic              illegal,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_branch,
  output logic [CNT_W-1:0]  cnt_taken
);

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYC - 1);

  brState_e   state, stateNext;
  logic [2:0] flushCnt;
  logic       taken, illegalF3, accept, takeBranch, condAccept;

  branch_decide uDecide (
    .valid     (br_valid),
    .jump      (br_jump),
    .funct3    (br_funct3),
    .brEq      (BrEQ),
    .brLt      (BrLT),
    .taken     (taken),
    .illegalF3 (illegalF3),
    .brUn      (BrUN)
  );

  assign br_ready   = (state == IDLE);
  assign accept     = br_valid & br_ready;
  assign takeBranch = accept & taken;
  assign condAccept = accept & ~br_jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // flushCnt holds the flush cycles still owed after the current one;
  // REDIRECT counts as the first flush cycle.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (takeBranch) stateNext = REDIRECT;
      REDIRECT: stateNext = (flushCnt == 3'd0) ? IDLE : FLUSH;
      FLUSH:    if (flushCnt <= 3'd1) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_sel    <= 1'b0;
      pc_target <= '0;
      flush     <= 1'b0;
      illegal   <= 1'b0;
      flushCnt  <= '0;
    end else begin
      pc_sel  <= (state == IDLE) & takeBranch;
      flush   <= (stateNext != IDLE);
      illegal <= condAccept & illegalF3;
      if ((state == IDLE) && takeBranch) begin
        pc_target <= br_target;
        flushCnt  <= FlushInit;
      end else if (state == FLUSH) begin
        flushCnt  <= flushCnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_branch <= '0;
      cnt_taken  <= '0;
    end else if (cnt_clr) begin
      cnt_branch <= '0;
      cnt_taken  <= '0;
    end else if (condAccept) begin
      cnt_branch <= cnt_branch + CNT_W'(1);
      if (taken) cnt_taken <= cnt_taken + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  localparam int DW = 32;
  localparam int FC = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          br_valid = 1'b0, br_jump = 1'b0, BrEQ = 1'b0, BrLT = 1'b0, cnt_clr = 1'b0;
  logic [2:0]    br_funct3 = 3'b0;
  logic [DW-1:0] br_target = '0;
  logic          BrUN, br_ready, pc_sel, flush, illegal;
  logic [DW-1:0] pc_target;
  logic [CW-1:0] cnt_branch, cnt_taken;

  branch_resolve #(.DATA_W(DW), .FLUSH_CYC(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_funct3(br_funct3),
    .br_jump(br_jump), .br_target(br_target), .BrEQ(BrEQ), .BrLT(BrLT),
    .BrUN(BrUN), .br_ready(br_ready), .pc_sel(pc_sel), .pc_target(pc_target),
    .flush(flush), .illegal(illegal), .cnt_clr(cnt_clr),
    .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nMis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: time-based. cyc counts posedges since reset release;
  // tAcc is the cycle index in which the last taken branch was accepted.
  int            cyc = 0;
  int            tAcc = -1000;
  logic [DW-1:0] mTarget = '0;
  logic [CW-1:0] mBr = '0, mTk = '0;
  logic          mIll = 1'b0;

  function automatic bit inFlush(input int c);
    return (c >= tAcc + 1) && (c <= tAcc + FC);
  endfunction

  function automatic bit refTaken(input logic j, input logic [2:0] f3,
                                  input logic eq, input logic lt);
    if (j) return 1'b1;
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic cycle(input logic v, input logic [2:0] f3, input logic j,
                       input logic [DW-1:0] tgt, input logic eq, input logic lt,
                       input logic clr);
    bit acc, tk;
    br_valid = v; br_funct3 = f3; br_jump = j; br_target = tgt;
    BrEQ = eq; BrLT = lt; cnt_clr = clr;
    @(negedge clk);
    chk("BrUN", 64'(BrUN), 64'(v & ~j & f3[1]));
    chk("br_ready", 64'(br_ready), 64'(!inFlush(cyc)));
    acc = v && !inFlush(cyc);
    tk  = refTaken(j, f3, eq, lt);
    if (acc && tk) begin tAcc = cyc; mTarget = tgt; end
    mIll = acc && !j && (f3 == 3'd2 || f3 == 3'd3);
    if (clr) begin mBr = '0; mTk = '0; end
    else if (acc && !j) begin mBr = mBr + 1'b1; if (tk) mTk = mTk + 1'b1; end
    @(posedge clk); cyc++; #1;
    chk("pc_sel", 64'(pc_sel), 64'(cyc == tAcc + 1));
    chk("flush", 64'(flush), 64'(inFlush(cyc)));
    chk("pc_target", 64'(pc_target), 64'(mTarget));
    chk("illegal", 64'(illegal), 64'(mIll));
    chk("cnt_branch", 64'(cnt_branch), 64'(mBr));
    chk("cnt_taken", 64'(cnt_taken), 64'(mTk));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 1'b0, '0, 1'bx, 1'bx, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst pc_sel", 64'(pc_sel), 64'd0);
    chk("rst flush", 64'(flush), 64'd0);
    chk("rst pc_target", 64'(pc_target), 64'd0);
    chk("rst cnt_branch", 64'(cnt_branch), 64'd0);
    chk("rst br_ready", 64'(br_ready), 64'd1);
    rst_n = 1'b1;

    // BEQ taken to 0x100, then flush window
    cycle(1'b1, 3'b000, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0);
    idle(3);
    // BGEU not taken (BrLT=1), unsigned compare
    cycle(1'b1, 3'b111, 1'b0, 32'h200, 1'b0, 1'b1, 1'b0);
    idle(1);
    // Taken BNE with a second branch held valid through the flush
    cycle(1'b1, 3'b001, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'b100, 1'b0, 32'h400, 1'b0, 1'b1, 1'b0);
    idle(3);
    // JAL with funct3=010: taken, not illegal, uncounted
    cycle(1'b1, 3'b010, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Illegal funct3 011
    cycle(1'b1, 3'b011, 1'b0, 32'h600, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Reset mid-redirect/flush: must clear asynchronously
    cycle(1'b1, 3'b101, 1'b0, 32'h700, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst pc_sel", 64'(pc_sel), 64'd0);
    chk("arst flush", 64'(flush), 64'd0);
    chk("arst pc_target", 64'(pc_target), 64'd0);
    chk("arst cnt_branch", 64'(cnt_branch), 64'd0);
    chk("arst cnt_taken", 64'(cnt_taken), 64'd0);
    chk("arst br_ready", 64'(br_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0; tAcc = -1000; mTarget = '0; mBr = '0; mTk = '0; mIll = 1'b0;
    idle(1);

    // Counter wrap: 16 taken BEQs wrap a 4-bit cnt_taken back to 0
    for (int i = 0; i < 3 * 16; i++)
      cycle(1'b1, 3'b000, 1'b0, 32'h1000 + DW'(i), 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("wrap cnt_taken", 64'(cnt_taken), 64'd0);
    // Clear beats a same-cycle taken increment
    cycle(1'b1, 3'b000, 1'b0, 32'h2000, 1'b1, 1'b0, 1'b1);
    chk("clr cnt_branch", 64'(cnt_branch), 64'd0);
    chk("clr cnt_taken", 64'(cnt_taken), 64'd0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic v;
      v = 1'($urandom % 2);
      cycle(v, 3'($urandom), ($urandom % 8) == 0, DW'($urandom),
            v ? 1'($urandom) : 1'bx, v ? 1'($urandom) : 1'bx,
            ($urandom % 16) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
